// File: rtl/enum_state_sequencer.sv
// A->B->C->D->A sequencer with per-state dwell and a valid/ready event for every state entry.
// Define ENUM_SEQ_TRACE_EN to add simulation-only event tracing and sanity stops.
// state | meaning: VAL_A idle, waits for go | VAL_B/VAL_C/VAL_D dwell phases, advance on dwell expiry
module enum_state_sequencer #(
  parameter int DWELL_W = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic               abort,
  input  logic [DWELL_W-1:0] cfg_dwell,
  output logic [1:0]         state,
  output logic [1:0]         other,
  output logic               evt_valid,
  output logic [1:0]         evt_state,
  input  logic               evt_ready,
  output logic [CNT_W-1:0]   trans_cnt,
  output logic               busy
);

  typedef enum logic [1:0] {VAL_A, VAL_B, VAL_C, VAL_D} state_t;
  typedef enum logic [1:0] {VAL_X, VAL_Y, VAL_Z} other_state_t;

  state_t             state_q;
  state_t             evt_state_q;
  other_state_t       other_q;
  logic               evt_valid_q;
  logic               busy_q;
  logic [CNT_W-1:0]   trans_cnt_q;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [DWELL_W-1:0] dwell_q;

  logic accept;
  logic dwell_done;
  logic can_adv;

  function automatic state_t succ(input state_t s);
    case (s)
      VAL_B:   succ = VAL_C;
      VAL_C:   succ = VAL_D;
      default: succ = VAL_A;
    endcase
  endfunction

  function automatic other_state_t other_of(input state_t s);
    case (s)
      VAL_A:   other_of = VAL_X;
      VAL_D:   other_of = VAL_Z;
      default: other_of = VAL_Y;
    endcase
  endfunction

  assign accept     = evt_valid_q && evt_ready;
  assign dwell_done = (dwell_cnt == dwell_q);
  // A pending event blocks the advance unless it is being accepted this very cycle.
  assign can_adv    = dwell_done && (!evt_valid_q || evt_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= VAL_A;
      other_q     <= VAL_X;
      evt_valid_q <= 1'b0;
      evt_state_q <= VAL_A;
      trans_cnt_q <= '0;
      busy_q      <= 1'b0;
      dwell_cnt   <= '0;
      dwell_q     <= '0;
    end else begin
      if (accept) trans_cnt_q <= trans_cnt_q + 1'b1;

      if (state_q == VAL_A) begin
        if (go && !abort) begin
          state_q     <= VAL_B;
          other_q     <= VAL_Y;
          busy_q      <= 1'b1;
          dwell_q     <= cfg_dwell;
          dwell_cnt   <= '0;
          evt_valid_q <= 1'b1;
          evt_state_q <= VAL_B;
        end else if (accept) begin
          evt_valid_q <= 1'b0;
        end
      end else if (abort) begin
        // Any pending event is overwritten; it is only counted if accepted this cycle.
        state_q     <= VAL_A;
        other_q     <= VAL_X;
        busy_q      <= 1'b0;
        dwell_cnt   <= '0;
        evt_valid_q <= 1'b1;
        evt_state_q <= VAL_A;
      end else if (can_adv) begin
        state_q     <= succ(state_q);
        other_q     <= other_of(succ(state_q));
        busy_q      <= (succ(state_q) != VAL_A);
        dwell_cnt   <= '0;
        evt_valid_q <= 1'b1;
        evt_state_q <= succ(state_q);
      end else begin
        if (!dwell_done) dwell_cnt <= dwell_cnt + 1'b1;
        if (accept) evt_valid_q <= 1'b0;
      end
    end
  end

  assign state     = state_q;
  assign other     = other_q;
  assign evt_valid = evt_valid_q;
  assign evt_state = evt_state_q;
  assign trans_cnt = trans_cnt_q;
  assign busy      = busy_q;

`ifdef ENUM_SEQ_TRACE_EN
  logic prev_valid;
  logic prev_excused;

  always_ff @(posedge clk) begin
    prev_valid   <= evt_valid_q;
    prev_excused <= rst || accept || (abort && state_q != VAL_A);
    if (!rst && accept) $write("[%0t] state=%s\n", $time, evt_state_q.name());
    if (other == 2'b11) $stop;
    if (prev_valid && !evt_valid_q && !prev_excused) $stop;
  end
`endif

endmodule

// File: tb/tb_enum_state_sequencer.sv
// Directed bench for enum_state_sequencer: a default instance and a CNT_W=2 instance driven in lockstep.
module tb_enum_state_sequencer;

  localparam logic [1:0] A = 2'd0, B = 2'd1, C = 2'd2, D = 2'd3;
  localparam logic [1:0] X = 2'd0, Y = 2'd1, Z = 2'd2;

  logic       clk = 1'b0;
  logic       rst, go, abort, evt_ready;
  logic [3:0] cfg_dwell;

  logic [1:0] state, other, evt_state;
  logic       evt_valid, busy;
  logic [7:0] trans_cnt;

  logic [1:0] state2, other2, evt_state2;
  logic       evt_valid2, busy2;
  logic [1:0] trans_cnt2;

  int tests = 0;
  int fails = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  enum_state_sequencer dut (
    .clk(clk), .rst(rst), .go(go), .abort(abort), .cfg_dwell(cfg_dwell),
    .state(state), .other(other), .evt_valid(evt_valid), .evt_state(evt_state),
    .evt_ready(evt_ready), .trans_cnt(trans_cnt), .busy(busy)
  );

  enum_state_sequencer #(.DWELL_W(4), .CNT_W(2)) dut_w2 (
    .clk(clk), .rst(rst), .go(go), .abort(abort), .cfg_dwell(cfg_dwell),
    .state(state2), .other(other2), .evt_valid(evt_valid2), .evt_state(evt_state2),
    .evt_ready(evt_ready), .trans_cnt(trans_cnt2), .busy(busy2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] other_model(input logic [1:0] s);
    if (s == A) return X;
    if (s == D) return Z;
    return Y;
  endfunction

  task automatic check_state(input string tag, input logic [1:0] s);
    check({tag, ".state"}, {30'd0, state}, {30'd0, s});
    check({tag, ".other"}, {30'd0, other}, {30'd0, other_model(s)});
    check({tag, ".busy"}, {31'd0, busy}, {31'd0, s != A});
    check({tag, ".state2"}, {30'd0, state2}, {30'd0, s});
  endtask

  task automatic check_evt(input string tag, input logic v, input logic [1:0] s);
    check({tag, ".evt_valid"}, {31'd0, evt_valid}, {31'd0, v});
    if (v) check({tag, ".evt_state"}, {30'd0, evt_state}, {30'd0, s});
  endtask

  task automatic check_cnt(input string tag);
    check({tag, ".cnt8"}, {24'd0, trans_cnt}, exp_cnt % 256);
    check({tag, ".cnt2"}, {30'd0, trans_cnt2}, exp_cnt % 4);
  endtask

  task automatic check_reset(input string tag);
    check_state(tag, A);
    check({tag, ".evt_valid"}, {31'd0, evt_valid}, 32'd0);
    check({tag, ".evt_state"}, {30'd0, evt_state}, 32'd0);
    check({tag, ".cnt8"}, {24'd0, trans_cnt}, 32'd0);
    check({tag, ".evt_valid2"}, {31'd0, evt_valid2}, 32'd0);
    check({tag, ".evt_state2"}, {30'd0, evt_state2}, 32'd0);
    check({tag, ".other2"}, {30'd0, other2}, 32'd0);
    check({tag, ".busy2"}, {31'd0, busy2}, 32'd0);
    check({tag, ".cnt2"}, {30'd0, trans_cnt2}, 32'd0);
  endtask

  // Dwell-0 loop with ready high: B, C, D, A one cycle each, then the A event is accepted.
  task automatic run_loop_d0(input string tag);
    logic [1:0] seq [4];
    seq[0] = C; seq[1] = D; seq[2] = A; seq[3] = A;
    cfg_dwell = 4'd0; evt_ready = 1'b1; go = 1'b1;
    tick();
    go = 1'b0;
    check_state({tag, ".b"}, B);
    check_evt({tag, ".b"}, 1'b1, B);
    check_cnt({tag, ".b"});
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_cnt++;
      check_state(tag, seq[k]);
      check_evt(tag, k != 3, seq[k]);
      check_cnt(tag);
    end
  endtask

  initial begin
    logic [1:0] full_seq [9];
    full_seq[0] = B; full_seq[1] = B; full_seq[2] = C; full_seq[3] = C; full_seq[4] = C;
    full_seq[5] = D; full_seq[6] = D; full_seq[7] = D; full_seq[8] = A;

    rst = 1'b1; go = 1'b0; abort = 1'b0; cfg_dwell = 4'd0; evt_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_reset("reset");
    for (int i = 0; i < 10; i++) begin
      tick();
      check_reset("idle");
    end

    // Full loop, dwell 2: B, C, D three cycles each.
    cfg_dwell = 4'd2; evt_ready = 1'b1; go = 1'b1;
    tick();
    go = 1'b0;
    cfg_dwell = 4'd9;
    check_state("loop.go", B);
    check_evt("loop.go", 1'b1, B);
    check_cnt("loop.go");
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 1 || k == 4 || k == 7) exp_cnt++;
      check_state("loop", full_seq[k-1]);
      check_cnt("loop");
    end
    check_evt("loop.end", 1'b1, A);
    tick();
    exp_cnt++;
    check_evt("loop.done", 1'b0, A);
    check_cnt("loop.done");
    check("loop.cnt4", {24'd0, trans_cnt}, 32'd4);

    // Backpressure with dwell 0.
    cfg_dwell = 4'd0; evt_ready = 1'b0; go = 1'b1;
    tick();
    go = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_state("bp.hold", B);
      check_evt("bp.hold", 1'b1, B);
      check_cnt("bp.hold");
    end
    evt_ready = 1'b1;
    tick();
    exp_cnt++;
    check_state("bp.adv", C);
    check_evt("bp.adv", 1'b1, C);
    check_cnt("bp.adv");
    tick(); exp_cnt++;
    check_state("bp.d", D);
    tick(); exp_cnt++;
    check_state("bp.a", A);
    tick(); exp_cnt++;
    check_evt("bp.done", 1'b0, A);
    check_cnt("bp.done");

    // Abort with a pending C event.
    cfg_dwell = 4'd0; evt_ready = 1'b1; go = 1'b1;
    tick();
    go = 1'b0;
    tick(); exp_cnt++;
    evt_ready = 1'b0;
    check_state("ab.c", C);
    check_evt("ab.c", 1'b1, C);
    check_cnt("ab.c");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_state("ab.a", A);
    check_evt("ab.a", 1'b1, A);
    check_cnt("ab.a");
    tick();
    check_evt("ab.wait", 1'b1, A);
    evt_ready = 1'b1;
    tick(); exp_cnt++;
    check_evt("ab.acc", 1'b0, A);
    check_cnt("ab.acc");

    // go and abort together in idle.
    go = 1'b1; abort = 1'b1;
    tick();
    go = 1'b0; abort = 1'b0;
    check_state("goab", A);
    check_evt("goab", 1'b0, A);
    tick();
    check_state("goab2", A);
    check_cnt("goab2");

    // Two dwell-0 loops; the 2-bit counter wraps.
    run_loop_d0("wrap1");
    run_loop_d0("wrap2");

    // Reset mid-loop in D.
    cfg_dwell = 4'd0; evt_ready = 1'b1; go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    tick();
    check_state("rst.d", D);
    rst = 1'b1;
    tick();
    check_reset("rst.mid");
    rst = 1'b0;
    tick();
    check_reset("rst.after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/enum_state_sequencer.md
# enum_state_sequencer

Sequential driver for the shared 2-bit `state_t` enum (`VAL_A`, `VAL_B`, `VAL_C`, `VAL_D`) and the companion 2-bit `other_state_t` enum (`VAL_X`, `VAL_Y`, `VAL_Z`).

- Sits directly upstream of the `MyIntf` sink interface and drives its `state` field.
- Walks `VAL_A` → `VAL_B` → `VAL_C` → `VAL_D` → `VAL_A` with a programmable dwell time per state.
- Publishes every state entry as a valid/ready event, so downstream consumers and waveform traces see each transition exactly once.

## Interface

Parameters:
- `DWELL_W`, default 4: width of the dwell configuration and the dwell counter.
- `CNT_W`, default 8: width of the accepted-transition counter.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset; **synchronous, active-high**.
- `go` in 1: start request; honoured only in `VAL_A`.
- `abort` in 1: force return to `VAL_A`.
- `cfg_dwell` in `DWELL_W`: dwell count; latched when `go` is accepted.
- `state` out 2 (`state_t`): current state; connects to `sink.state`.
- `other` out 2 (`other_state_t`): derived secondary enum.
- `evt_valid` out 1: transition event pending.
- `evt_state` out 2 (`state_t`): state carried by the pending event.
- `evt_ready` in 1: consumer accepts the event.
- `trans_cnt` out `CNT_W`: count of accepted events.
- `busy` out 1: high whenever `state != VAL_A`.

## Operation

Reset (`rst`=1 at a rising edge) sets:
- `state` = `VAL_A`
- `other` = `VAL_X`
- `evt_valid` = 0
- `evt_state` = `VAL_A`
- `trans_cnt` = 0
- `busy` = 0
- internal dwell counter and latched dwell = 0

Reset overrides all other inputs, including mid-sequence and with an event pending.

State transitions:
- **`VAL_A`:** idle. `go`=1 and `abort`=0 → `VAL_B`, with `cfg_dwell` latched as `dwell_q`.
- **`VAL_B`, `VAL_C`, `VAL_D`:**
  - The dwell counter clears to 0 on state entry and increments each cycle in the state, saturating at `dwell_q`.
  - The state advances (`B`→`C`→`D`→`A`) at the edge where counter == `dwell_q` **and** no event is pending, or the pending event is accepted in that same cycle.
  - Otherwise the state holds (backpressure).
- **`abort`=1 in any non-A state:** `state` → `VAL_A` next edge, regardless of dwell or pending event.
- **`abort`=1 in `VAL_A`:** no effect, and it suppresses a simultaneous `go`.

Events:
- Every state change (including the return to `VAL_A` and any abort) sets `evt_valid`=1 and `evt_state` to the new state on the same edge the state changes.
- Handshake: an event is accepted in any cycle with `evt_valid && evt_ready`. `evt_valid` drops next edge unless a new state change occurs on that edge.
- `evt_valid` and `evt_state` stay stable while unaccepted.
- Exception for abort: an abort with an event pending overwrites `evt_state` with `VAL_A` and keeps `evt_valid`=1. The overwritten event is lost and not counted.
- `trans_cnt` increments by 1 per accepted event and wraps modulo 2^`CNT_W`.

Derived outputs:
- `other` is registered alongside `state`:
  - `VAL_A` → `VAL_X`
  - `VAL_B` or `VAL_C` → `VAL_Y`
  - `VAL_D` → `VAL_Z`
- Encoding 2'b11 never appears on `other`.

## Timing

- `go` sampled at edge N → `state`=`VAL_B` and `evt_valid`=1 after edge N. Latency 1 cycle.
- With `evt_ready` tied high, each of `B`, `C`, `D` lasts exactly `dwell_q`+1 cycles.
  - Full round trip `A`→`A` takes 3·(`dwell_q`+1)+1 cycles from `go`.
- `dwell_q`=0: each non-A state lasts 1 cycle.
- Backpressure: with `evt_ready`=0, the state stalls at dwell expiry until the acceptance cycle, then advances on that same edge.
- `abort` latency: 1 cycle to `VAL_A`. `busy` falls on the same edge.
- There are no combinational paths from inputs to outputs.

## Configuration

- `ENUM_SEQ_TRACE_EN` defined:
  - The block executes `$write("[%0t] state=%s\n", $time, evt_state.name())` on every accepted event.
  - It issues `$stop` if `other` is ever 2'b11, or if `evt_valid` drops without acceptance, except when reset or abort overwrote the event.
- `ENUM_SEQ_TRACE_EN` undefined:
  - No simulation-only statements are present.
  - Synthesizable behaviour and ports are identical in both cases.

## Test plan

- Reset then idle: `rst`=1 for 2 cycles, then 10 idle cycles → `state`=`VAL_A`, `other`=`VAL_X`, `evt_valid`=0, `trans_cnt`=0 throughout.
- Full loop: `cfg_dwell`=2, `evt_ready`=1, pulse `go` → `B`,`C`,`D` each 3 cycles; `other` shows `Y`,`Y`,`Z`; back at `VAL_A` 10 cycles after `go`; `trans_cnt`=4.
- Backpressure: `cfg_dwell`=0, `evt_ready`=0 for 5 cycles after `go` → `state` holds `VAL_B` and `evt_state`=`VAL_B`; after `evt_ready`=1 the state advances to `VAL_C` on the acceptance edge.
- Abort with pending event: enter `VAL_C` with `evt_ready`=0, assert `abort` → next cycle `state`=`VAL_A`, `evt_state`=`VAL_A`, `evt_valid`=1; after acceptance `trans_cnt` increments by 1 only.
- Simultaneous `go`+`abort` in `VAL_A` → stays `VAL_A`, no event.
- Counter wrap and reset: `CNT_W`=2, run 2 full loops with `cfg_dwell`=0 → `trans_cnt` wraps to 0 after 4 events. Assert `rst` mid-loop in `VAL_D` → all outputs return to reset values next edge.
